// File: rtl/math_rp_sched.sv
// math_rp_sched: round-robin sharing of one math_rp with PR decouple sequencing.
// Define MATH_RP_SCHED_SELFCHECK_EN to add the adder-RM check and err_mismatch.
module math_rp_sched #(
   parameter int NREQ = 4,
   parameter int LAT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_in1,
   input  logic [4*NREQ-1:0] req_in2,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_data,
   output logic [3:0]        rp_in1,
   output logic [3:0]        rp_in2,
   output logic              rp_reset,
   input  logic [7:0]        rp_out,
   input  logic              decouple_req,
   output logic              decouple_ack,
   output logic              busy
`ifdef MATH_RP_SCHED_SELFCHECK_EN
   ,output logic             err_mismatch
`endif
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DECOUPLED} state_t;
   function automatic logic [PW-1:0] wrap(input int v);
      return PW'((v >= NREQ) ? v - NREQ : v);
   endfunction
   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, pick;
   logic [2:0]      cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic [3:0]      rp_in1_q, rp_in1_d, rp_in2_q, rp_in2_d;
   logic            rp_reset_q, rp_reset_d, ack_q, ack_d, busy_q, busy_d, rel_q, rel_d;
   logic            found;
   // scanning offsets downward leaves the lowest offset from ptr as the winner
   always_comb begin
      found = 1'b0;
      pick = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[wrap(int'(ptr_q) + k)]) begin
            found = 1'b1;
            pick = wrap(int'(ptr_q) + k);
         end
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      win_d = win_q;
      cnt_d = cnt_q;
      gnt_d = '0;
      rsp_valid_d = '0;
      rsp_data_d = rsp_data_q;
      rp_in1_d = rp_in1_q;
      rp_in2_d = rp_in2_q;
      ack_d = ack_q;
      busy_d = busy_q;
      rel_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (decouple_req) begin
               state_d = S_DECOUPLED;
               ack_d = 1'b1;
               rp_in1_d = '0;
               rp_in2_d = '0;
            end else if (found && !rel_q) begin
               state_d = S_WAIT;
               gnt_d[pick] = 1'b1;
               rp_in1_d = req_in1[4*int'(pick) +: 4];
               rp_in2_d = req_in2[4*int'(pick) +: 4];
               cnt_d = 3'(LAT);
               busy_d = 1'b1;
               win_d = pick;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            state_d = (cnt_d == 3'd0) ? S_CAPTURE : S_WAIT;
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
            rsp_data_d = rp_out;
            rsp_valid_d[win_q] = 1'b1;
            busy_d = 1'b0;
            ptr_d = wrap(int'(win_q) + 1);
         end
         default: begin
            state_d = decouple_req ? S_DECOUPLED : S_IDLE;
            ack_d = decouple_req;
            rel_d = !decouple_req;
         end
      endcase
      // the release cycle keeps the RP in reset one extra IDLE cycle
      rp_reset_d = (state_d == S_DECOUPLED) || rel_d;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q <= '0;
         win_q <= '0;
         cnt_q <= '0;
         gnt_q <= '0;
         rsp_valid_q <= '0;
         rsp_data_q <= '0;
         rp_in1_q <= '0;
         rp_in2_q <= '0;
         rp_reset_q <= 1'b1;
         ack_q <= 1'b0;
         busy_q <= 1'b0;
         rel_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         win_q <= win_d;
         cnt_q <= cnt_d;
         gnt_q <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q <= rsp_data_d;
         rp_in1_q <= rp_in1_d;
         rp_in2_q <= rp_in2_d;
         rp_reset_q <= rp_reset_d;
         ack_q <= ack_d;
         busy_q <= busy_d;
         rel_q <= rel_d;
      end
   end
   assign gnt = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data = rsp_data_q;
   assign rp_in1 = rp_in1_q;
   assign rp_in2 = rp_in2_q;
   assign rp_reset = rp_reset_q;
   assign decouple_ack = ack_q;
   assign busy = busy_q;
`ifdef MATH_RP_SCHED_SELFCHECK_EN
   // the adder RM must return 2*in1 + in2 from the operands still held on rp_in*
   logic       err_q, err_d;
   logic [5:0] exp_sum;
   always_comb begin
      exp_sum = {1'b0, rp_in1_q, 1'b0} + {2'b00, rp_in2_q};
      err_d = err_q | ((state_q == S_CAPTURE) && (rp_out != {2'b00, exp_sum}));
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else err_q <= err_d;
   end
   assign err_mismatch = err_q;
`endif
endmodule

// File: tb/tb_math_rp_sched.sv
// tb_math_rp_sched: directed vectors and sequences for math_rp_sched (NREQ=4, LAT=1)
// with a one-cycle adder RP model that can be forced to return a fixed value.
module tb_math_rp_sched;
   logic        clk, reset;
   logic [3:0]  req, gnt, rsp_valid, rp_in1, rp_in2;
   logic [15:0] req_in1, req_in2;
   logic [7:0]  rsp_data, rp_out, rp_force;
   logic        rp_reset, decouple_req, decouple_ack, busy, rp_forced;
   logic [5:0]  sum6;
`ifdef MATH_RP_SCHED_SELFCHECK_EN
   logic        err_mismatch;
`endif
   int total = 0, bad = 0;
   typedef struct {
      logic [3:0]  rq;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  g;
      logic [7:0]  d;
   } vec_t;
   vec_t tbl [8];
   math_rp_sched #(.NREQ(4), .LAT(1)) dut (
      .clk(clk), .reset(reset), .req(req), .req_in1(req_in1), .req_in2(req_in2),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rp_in1(rp_in1), .rp_in2(rp_in2), .rp_reset(rp_reset), .rp_out(rp_out),
      .decouple_req(decouple_req), .decouple_ack(decouple_ack), .busy(busy)
`ifdef MATH_RP_SCHED_SELFCHECK_EN
      ,.err_mismatch(err_mismatch)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign sum6 = {1'b0, rp_in1, 1'b0} + {2'b00, rp_in2};
   always_ff @(posedge clk) rp_out <= rp_reset ? 8'd0 : (rp_forced ? rp_force : {2'b00, sum6});
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic do_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      tick;
   endtask
   task automatic run_vec(input int n, input vec_t v);
      req = v.rq;
      req_in1 = v.a;
      req_in2 = v.b;
      tick;
      chk($sformatf("v%0d_gnt", n), gnt, v.g);
      chk($sformatf("v%0d_busy", n), busy, 1);
      req = '0;
      tick;
      chk($sformatf("v%0d_rsp_early", n), rsp_valid, 0);
      tick;
      chk($sformatf("v%0d_rsp_valid", n), rsp_valid, v.g);
      chk($sformatf("v%0d_rsp_data", n), rsp_data, v.d);
      chk($sformatf("v%0d_busy_done", n), busy, 0);
   endtask
   initial begin
      tbl[0] = '{4'b0100, 16'h3521, 16'h4312, 4'b0100, 8'd13};
      tbl[1] = '{4'b0011, 16'h0021, 16'h0032, 4'b0001, 8'd4};
      tbl[2] = '{4'b0011, 16'h00F1, 16'h00F2, 4'b0010, 8'd45};
      tbl[3] = '{4'b1001, 16'h7006, 16'h0001, 4'b1000, 8'd14};
      tbl[4] = '{4'b1001, 16'h7000, 16'h5009, 4'b0001, 8'd9};
      tbl[5] = '{4'b0001, 16'h0008, 16'h0004, 4'b0001, 8'd20};
      tbl[6] = '{4'b1110, 16'hABC0, 16'h123F, 4'b0010, 8'd27};
      tbl[7] = '{4'b1110, 16'hABC0, 16'h123F, 4'b0100, 8'd24};
      reset = 1'b1;
      req = '0;
      req_in1 = '0;
      req_in2 = '0;
      decouple_req = 1'b0;
      rp_forced = 1'b0;
      rp_force = '0;
      tick;
      tick;
      chk("rst_gnt", gnt, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rp_in1", rp_in1, 0);
      chk("rst_rp_in2", rp_in2, 0);
      chk("rst_rp_reset", rp_reset, 1);
      chk("rst_ack", decouple_ack, 0);
      chk("rst_busy", busy, 0);
`ifdef MATH_RP_SCHED_SELFCHECK_EN
      chk("rst_err", err_mismatch, 0);
`endif
      reset = 1'b0;
      tick;
      chk("rst_rp_reset_clear", rp_reset, 0);
      // all four requesting continuously: 0,1,2,3,0 one grant every 3 cycles
      req = 4'b1111;
      req_in1 = 16'h4321;
      req_in2 = 16'h0000;
      for (int k = 0; k < 13; k++) begin
         tick;
         chk($sformatf("rr%0d_gnt", k), gnt, (k % 3 == 0) ? 4'(1 << ((k / 3) % 4)) : 4'd0);
         chk($sformatf("rr%0d_rsp", k), rsp_valid, (k % 3 == 2) ? 4'(1 << (k / 3)) : 4'd0);
         if (k % 3 == 2) chk($sformatf("rr%0d_data", k), rsp_data, 2 * (k / 3 + 1));
      end
      req = '0;
      tick;
      tick;
      chk("rr_last_rsp", rsp_valid, 4'b0001);
      chk("rr_last_data", rsp_data, 2);
      tick;
      chk("rr_data_hold", rsp_data, 2);
      do_reset;
      for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);
`ifdef MATH_RP_SCHED_SELFCHECK_EN
      chk("sc_err_after_good", err_mismatch, 0);
`endif
      // decouple raised mid-operation: response still delivered, then isolation
      req = 4'b0001;
      req_in1 = 16'h0005;
      req_in2 = 16'h0003;
      tick;
      chk("dc_gnt", gnt, 4'b0001);
      req = '0;
      decouple_req = 1'b1;
      tick;
      chk("dc_wait_ack", decouple_ack, 0);
      chk("dc_wait_busy", busy, 1);
      tick;
      chk("dc_rsp_valid", rsp_valid, 4'b0001);
      chk("dc_rsp_data", rsp_data, 13);
      chk("dc_cap_ack", decouple_ack, 0);
      tick;
      chk("dc_ack", decouple_ack, 1);
      chk("dc_rp_reset", rp_reset, 1);
      chk("dc_rp_in1", rp_in1, 0);
      chk("dc_rp_in2", rp_in2, 0);
      req = 4'b1111;
      req_in1 = 16'h0020;
      req_in2 = 16'h0010;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk($sformatf("dc_hold%0d_gnt", k), gnt, 0);
         chk($sformatf("dc_hold%0d_ack", k), decouple_ack, 1);
         chk($sformatf("dc_hold%0d_rp_reset", k), rp_reset, 1);
      end
      decouple_req = 1'b0;
      tick;
      chk("rel_ack", decouple_ack, 0);
      chk("rel_rp_reset", rp_reset, 1);
      chk("rel_gnt0", gnt, 0);
      tick;
      chk("rel_rp_reset_clear", rp_reset, 0);
      chk("rel_gnt1", gnt, 0);
      tick;
      chk("rel_gnt2", gnt, 4'b0010);
      req = '0;
      tick;
      tick;
      chk("rel_rsp_valid", rsp_valid, 4'b0010);
      chk("rel_rsp_data", rsp_data, 5);
      decouple_req = 1'b1;
      tick;
      chk("idle_dc_ack", decouple_ack, 1);
      decouple_req = 1'b0;
      tick;
      chk("idle_rel_ack", decouple_ack, 0);
      chk("idle_rel_rp_reset", rp_reset, 1);
      tick;
      chk("idle_rel_rp_reset_clear", rp_reset, 0);
      // reset one cycle after a grant drops the operation and rewinds ptr
      req = 4'b0010;
      req_in1 = 16'h0070;
      req_in2 = 16'h0010;
      tick;
      chk("mr_gnt", gnt, 4'b0010);
      req = '0;
      tick;
      reset = 1'b1;
      #1;
      chk("mr_gnt_rst", gnt, 0);
      chk("mr_rsp_valid_rst", rsp_valid, 0);
      chk("mr_rsp_data_rst", rsp_data, 0);
      chk("mr_rp_in1_rst", rp_in1, 0);
      chk("mr_rp_reset_rst", rp_reset, 1);
      chk("mr_busy_rst", busy, 0);
      tick;
      chk("mr_no_rsp", rsp_valid, 0);
      req = 4'b1010;
      req_in1 = 16'h9040;
      req_in2 = 16'h0060;
      reset = 1'b0;
      tick;
      chk("mr_next_gnt", gnt, 4'b0010);
      req = '0;
      tick;
      tick;
      chk("mr_next_rsp", rsp_valid, 4'b0010);
      chk("mr_next_data", rsp_data, 14);
`ifdef MATH_RP_SCHED_SELFCHECK_EN
      // a subtracting RM returns 30 for 15,15 instead of 45
      chk("sc_err_clean", err_mismatch, 0);
      rp_forced = 1'b1;
      rp_force = 8'd30;
      req = 4'b0001;
      req_in1 = 16'h000F;
      req_in2 = 16'h000F;
      tick;
      chk("sc_gnt", gnt, 4'b0001);
      req = '0;
      tick;
      tick;
      chk("sc_data", rsp_data, 30);
      chk("sc_err_set", err_mismatch, 1);
      rp_forced = 1'b0;
      run_vec(8, tbl[0]);
      chk("sc_err_sticky", err_mismatch, 1);
      do_reset;
      chk("sc_err_reset", err_mismatch, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/math_rp_sched.md
# math_rp_sched

Round-robin scheduler that shares one reconfigurable `math_rp` instance between `NREQ` requesters. It registers the winning requester's operands onto the RP inputs, waits the RP's fixed pipeline latency, and returns the 8-bit result to that requester. It also sequences partial-reconfiguration decoupling: it drains any in-flight operation, holds the RP in reset while decoupled, and releases it cleanly afterwards. It sits in the static region, between the request sources and the `math_rp` boundary.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 1: RP latency in cycles, from `rp_in1`/`rp_in2` stable to `rp_out` valid, 1..7.
- `clk` in 1: single clock, shared with `math_rp`.
- `reset` in 1: asynchronous, active-high.
- `req` in NREQ: per-requester request level.
- `req_in1` in 4*NREQ: operand 1; requester i uses bits [4i+3:4i].
- `req_in2` in 4*NREQ: operand 2, same packing as `req_in1`.
- `gnt` out NREQ: one-hot, one-cycle pulse; operands taken.
- `rsp_valid` out NREQ: one-hot, one-cycle pulse; `rsp_data` is valid for that requester.
- `rsp_data` out 8: result; holds its last value between pulses.
- `rp_in1` out 4: to `math_rp` `in1`.
- `rp_in2` out 4: to `math_rp` `in2`.
- `rp_reset` out 1: to `math_rp` `reset_vio`.
- `rp_out` in 8: from `math_rp` `out`.
- `decouple_req` in 1: PR controller requests isolation.
- `decouple_ack` out 1: RP is idle and isolated.
- `busy` out 1: operation in flight.
- `err_mismatch` out 1: sticky self-check flag. Present only with the macro described under Configuration.

## Operation
- FSM states:
  - IDLE → WAIT on `|req` and `!decouple_req`.
  - IDLE → DECOUPLED on `decouple_req`. Decouple has priority over pending requests.
  - WAIT → CAPTURE when `cnt == 0`.
  - CAPTURE → IDLE.
  - DECOUPLED → IDLE when `decouple_req` falls.
- Arbitration:
  - Round-robin starting at pointer `ptr`.
  - The winner is the lowest index ≥ `ptr` with `req` set, wrapping modulo NREQ.
  - After CAPTURE, `ptr` becomes winner+1 modulo NREQ. NREQ-1 wraps to 0.
- Issue (IDLE → WAIT edge):
  - `gnt[w]` = 1 for one cycle.
  - `rp_in1`/`rp_in2` are loaded from slot w.
  - `cnt` = LAT, `busy` = 1, winner index is latched.
- WAIT:
  - `cnt` decrements each cycle.
  - `rp_in*` is held stable.
  - `decouple_req` is ignored until CAPTURE.
- CAPTURE edge:
  - `rsp_data` ← `rp_out`.
  - `rsp_valid[w]` = 1 for one cycle.
  - `busy` = 0.
- Requester rule:
  - Hold `req` and operands stable until `gnt`.
  - `req` still high in the cycle after `gnt` is a new request.
  - Only one operation is ever outstanding.
- DECOUPLED:
  - `decouple_ack` = 1 and `rp_reset` = 1.
  - `rp_in*` = 0.
  - No grants are issued.
  - `rp_out` is ignored.
- Release: on leaving DECOUPLED, `rp_reset` stays 1 for exactly one more cycle (the first IDLE cycle), and no grant is issued in that cycle.
- Width: `rp_out` is passed through unmodified. No arithmetic is done in this block except the self-check.

## Timing
- Reset values:
  - FSM = IDLE, `ptr` = 0.
  - `gnt` = 0, `rsp_valid` = 0, `rsp_data` = 0.
  - `rp_in1` = `rp_in2` = 0.
  - `rp_reset` = 1, cleared on the first clock edge after reset deasserts.
  - `decouple_ack` = 0, `busy` = 0, `err_mismatch` = 0.
- All outputs are registered.
- Request to response: `req` sampled at edge E0 → `gnt` high E0–E1 → `rsp_valid` high at E(LAT+1)–E(LAT+2).
- Throughput: one operation per LAT+2 cycles.
- Decouple:
  - `decouple_req` sampled in IDLE → `decouple_ack` asserts on the next edge.
  - `decouple_req` in WAIT → `decouple_ack` asserts one edge after CAPTURE.
  - `decouple_ack` falls on the edge that samples `decouple_req` low.
- Reset mid-operation: the operation is dropped, no `rsp_valid` is produced, and `ptr` returns to 0.

## Configuration
- `MATH_RP_SCHED_SELFCHECK_EN` defined:
  - At CAPTURE, `rp_out` is compared with `{2'b0, 2*in1 + in2}` (6-bit sum, zero-extended) computed from the latched operands.
  - Any mismatch sets `err_mismatch`. It clears only on `reset`.
  - Used to confirm that the adder RM is loaded.
- Undefined: the comparator and `err_mismatch` port are absent; behaviour is otherwise identical.

## Test plan
- LAT=1, `req[2]`=1, in1=5, in2=3, RP model returns 13 → `gnt[2]` at E0, `rsp_valid[2]` at E2, `rsp_data`=13.
- `req`=4'b1111 held continuously → grants in order 0,1,2,3,0, one every 3 cycles, with no starvation.
- `decouple_req` rises in WAIT → response still delivered; `decouple_ack`=1 the next cycle; `rp_reset`=1; no `gnt` while decoupled.
- `decouple_req` falls → `decouple_ack`=0; `rp_reset` high for one more cycle; first grant occurs 2 cycles after release.
- `reset` pulsed one cycle after `gnt` → no `rsp_valid`, all outputs at reset values, next grant goes to the lowest active index.
- SELFCHECK on, in1=15, in2=15, RP returns 45 → `err_mismatch`=0; RP returns 30 (subtract RM) → `err_mismatch`=1, sticky.
